// File: rtl/fabm_pkg.sv
// fabm_pkg: shared definitions for the FABM partial-product accumulator.
//   TRUNC_LSB / PROD_W / OUT_W / NUM_PP : product geometry
//   state_t     : accumulator control states
//   booth_t     : radix-4 Booth digit in {-2..2}
//   booth_digit : window {b[2k+1], b[2k], b[2k-1]} -> digit
package fabm_pkg;

  localparam int TRUNC_LSB = 14;
  localparam int PROD_W    = 64;
  localparam int OUT_W     = PROD_W - TRUNC_LSB;
  localparam int NUM_PP    = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  typedef logic signed [2:0] booth_t;

  function automatic booth_t booth_digit(input logic [2:0] win);
    booth_t d;
    case (win)
      3'b001, 3'b010: d = 3'sd1;
      3'b011:         d = 3'sd2;
      3'b100:         d = -3'sd2;
      3'b101, 3'b110: d = -3'sd1;
      default:        d = 3'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fabm_booth_row.sv
// fabm_booth_row: one radix-4 Booth partial-product row (combinational).
// Ports:
//   a   in  32  signed multiplicand
//   win in  3   Booth window {b[2k+1], b[2k], b[2k-1]}
//   k   in  4   row index; the row is weighted by 4^k
//   row out 64  (digit * a) << 2k as a full two's-complement value
module fabm_booth_row (
  input  logic signed [31:0] a,
  input  logic        [2:0]  win,
  input  logic        [3:0]  k,
  output logic signed [63:0] row
);
  import fabm_pkg::*;

  booth_t             d;
  logic signed [63:0] ax;
  logic signed [63:0] mag;

  assign d  = booth_digit(win);
  assign ax = {{32{a[31]}}, a};

  // Negation is completed here, so no separate "+1" hot bit is needed
  // downstream in the CSA tree.
  always_comb begin
    mag = '0;
    case (d)
      3'sd1:   mag = ax;
      3'sd2:   mag = ax <<< 1;
      -3'sd1:  mag = -ax;
      -3'sd2:  mag = -(ax <<< 1);
      default: mag = '0;
    endcase
  end

  assign row = mag <<< {k, 1'b0};

endmodule

// File: rtl/fabm_pg_accum.sv
// fabm_pg_accum: sequential Booth partial-product accumulator feeding the
// FABM 32x32 final carry-chain adder. Rows are summed in carry-save form
// (S, C), PP_PER_CYCLE rows per clock; bits [63:14] leave as prop/gen/cin.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b signed 32-bit)
//   out_valid/out_ready result handshake
//   prop  [49:0]        S[63:14] ^ C[63:14]
//   gen   [49:0]        S[63:14]
//   cin                 carry into bit 14
// Optional build macro FABM_EXACT_CIN_EN: cin is the true carry-out of
// S[13:0]+C[13:0] instead of the S[13]|C[13] approximation.
module fabm_pg_accum #(
  parameter int PP_PER_CYCLE = 2,
  parameter int TRUNC_LSB    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [31:0]         a,
  input  logic signed [31:0]         b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [fabm_pkg::OUT_W-1:0] prop,
  output logic [fabm_pkg::OUT_W-1:0] gen,
  output logic                       cin
);
  import fabm_pkg::*;

  if (!(PP_PER_CYCLE == 1 || PP_PER_CYCLE == 2 || PP_PER_CYCLE == 4)) begin : g_bad_pp
    $error("fabm_pg_accum: PP_PER_CYCLE must be 1, 2 or 4");
  end
  if (TRUNC_LSB != fabm_pkg::TRUNC_LSB) begin : g_bad_trunc
    $error("fabm_pg_accum: TRUNC_LSB is fixed at 14");
  end

  localparam int         STEPS = NUM_PP / PP_PER_CYCLE;
  localparam logic [3:0] LAST  = 4'(STEPS - 1);

  state_t                    state_q, state_d;
  logic        [3:0]         cnt_q;
  logic signed [31:0]        a_q, b_q;
  logic        [PROD_W-1:0]  s_q, c_q, s_d, c_d;
  logic        [32:0]        bext;
  logic signed [PROD_W-1:0]  row [PP_PER_CYCLE];

  // b[-1] = 0 sits below bit 0 of the window source.
  assign bext = {b_q, 1'b0};

  for (genvar j = 0; j < PP_PER_CYCLE; j++) begin : g_row
    logic [3:0] k;
    logic [5:0] bpos;
    logic [2:0] win;
    assign k    = 4'(int'(cnt_q) * PP_PER_CYCLE + j);
    assign bpos = {1'b0, k, 1'b0};
    assign win  = {bext[bpos + 6'd2], bext[bpos + 6'd1], bext[bpos]};
    fabm_booth_row u_row (
      .a   (a_q),
      .win (win),
      .k   (k),
      .row (row[j])
    );
  end

  // Chain of 3:2 compressors; each row folds into (S, C) modulo 2^64.
  always_comb begin
    logic [PROD_W-1:0] sum_v;
    s_d = s_q;
    c_d = c_q;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      sum_v = s_d ^ c_d ^ row[j];
      c_d   = ((s_d & c_d) | (s_d & row[j]) | (c_d & row[j])) << 1;
      s_d   = sum_v;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = ACCUM;
      ACCUM:   if (cnt_q == LAST) state_d = HOLD;
      HOLD:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // ---- accumulate stage: state, operand latch, (S, C) registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= b;
          s_q   <= '0;
          c_q   <= '0;
          cnt_q <= '0;
        end
        ACCUM: begin
          s_q   <= s_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---- output stage: combinational from the held (S, C) ----
  logic cin_raw;
`ifdef FABM_EXACT_CIN_EN
  logic [TRUNC_LSB:0] lo_sum;
  assign lo_sum  = {1'b0, s_q[TRUNC_LSB-1:0]} + {1'b0, c_q[TRUNC_LSB-1:0]};
  assign cin_raw = lo_sum[TRUNC_LSB];
`else
  // Approximate compensation for the discarded low columns.
  assign cin_raw = s_q[TRUNC_LSB-1] | c_q[TRUNC_LSB-1];
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign prop = out_valid ? (s_q[PROD_W-1:TRUNC_LSB] ^ c_q[PROD_W-1:TRUNC_LSB]) : '0;
  assign gen  = out_valid ? s_q[PROD_W-1:TRUNC_LSB] : '0;
  assign cin  = out_valid & cin_raw;

endmodule

// File: tb/tb_fabm_pg_accum.sv
// Scoreboard bench for fabm_pg_accum: stimulus pushes expected
// product[63:14] values; a negedge monitor pops and compares on each fire.
module tb_fabm_pg_accum;
  parameter int PP = 2;
  localparam int LAT = 16 / PP;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, cin;
  logic [31:0] a, b;
  logic [49:0] prop, gen;

  typedef struct packed {
    logic [49:0] val;
    logic        tol;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fabm_pg_accum #(.PP_PER_CYCLE(PP), .TRUNC_LSB(14)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .prop(prop), .gen(gen), .cin(cin)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: carry-chain sum = S + C + cin over bits [63:14], with C = prop^gen.
  always @(negedge clk) begin
    logic [49:0] s, d;
    exp_t        e;
    if (!rst && out_valid && out_ready) begin
      s = gen + (prop ^ gen) + {49'd0, cin};
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected no output", s);
      end else begin
        e = sbq.pop_front();
        d = s - e.val;
        if (!(d == 50'd0 || (e.tol && (d == 50'd1 || d == {50{1'b1}})))) begin
          n_err++;
          $display("FAIL sb_sum: got %0h expected %0h (tol %0d)", s, e.val, e.tol);
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic [49:0] ev, input logic tol, input bit push);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    a = av; b = bv; in_valid = 1'b1;
    if (push) sbq.push_back('{val: ev, tol: tol});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid; optionally pokes a stray operand during ACCUM.
  task automatic await_out(input bit noise);
    int lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 1) begin
        check("accum_ctrl", {in_ready, out_valid}, 2'b00);
        check("accum_zero", {prop, gen, cin}, 101'd0);
      end
      if (noise && lat == 2) begin
        in_valid = 1'b1; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, LAT);
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv,
                     input logic [49:0] ev, input bit noise);
    send(av, bv, ev, 1'b0, 1'b1);
    await_out(noise);
    @(posedge clk); #1;
    check("after_fire", {in_ready, out_valid}, 2'b10);
  endtask

  localparam logic [49:0] ALL1 = {50{1'b1}};

  initial begin
    logic [49:0] p0, g0, ev;
    logic        c0;
    logic [63:0] prod;
    int          sa, sb, nrand;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {in_ready, out_valid}, 2'b10);
    check("reset_data", {prop, gen, cin}, 101'd0);
    rst = 1'b0;

    // Directed products (hand-computed bits [63:14]).
    run(32'd3, 32'd5, 50'd0, 1'b1);
    run(32'h0001_0000, 32'h0001_0000, 50'd262144, 1'b0);
    run(32'h8000_0000, 32'h8000_0000, 50'h1_0000_0000_0000, 1'b0);
    run(32'hFFFF_FFFF, 32'h0000_4000, ALL1, 1'b0);

    // Back-pressure: hold for 20 cycles with out_ready low.
    out_ready = 1'b0;
    send(32'h0001_0000, 32'h0001_0000, 50'd262144, 1'b0, 1'b1);
    await_out(1'b0);
    p0 = prop; g0 = gen; c0 = cin;
    check("hold_gen", g0, 50'd262144);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {prop, gen, cin, in_ready, out_valid}, {p0, g0, c0, 1'b0, 1'b1});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {in_ready, out_valid}, 2'b10);

    // Reset in the 4th ACCUM cycle discards the partial product.
    send(32'd7, 32'd9, 50'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ctrl", {in_ready, out_valid}, 2'b10);
    check("rst_data", {prop, gen, cin}, 101'd0);

    // 2 * -3 = -6: S ends at -6 with C = 0, so S[13] = 1 feeds the
    // approximate cin and wraps the upper sum to 0.
`ifdef FABM_EXACT_CIN_EN
    run(32'd2, 32'hFFFF_FFFD, ALL1, 1'b0);
    nrand = 3000;
`else
    run(32'd2, 32'hFFFF_FFFD, 50'd0, 1'b0);
    nrand = 40;
`endif

    for (int i = 0; i < nrand; i++) begin
      sa = int'($urandom);
      sb = int'($urandom);
      prod = 64'(longint'(sa) * longint'(sb));
      ev = prod[63:14];
`ifdef FABM_EXACT_CIN_EN
      send(32'(sa), 32'(sb), ev, 1'b0, 1'b1);
`else
      send(32'(sa), 32'(sb), ev, 1'b1, 1'b1);
`endif
      await_out(1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
